rf_writeback_queue: RTL

Write-side companion of the register unit in the pipelined core. Collects writeback requests from the single-cycle ALU path and the variable-latency memory/load path, holds them in a small in-order queue, and retires exactly one write per cycle onto the register unit's write port (RUWr/rd/RUDataWr). Also provides rs1/rs2 forwarding of still-pending writes to decode, so reads never see stale register values while a write is queued.

---
 rtl/rf_writeback_queue_if.sv | 36 +++
 rtl/rf_writeback_queue.sv | 130 +++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue_if.sv
// Writeback request and register-unit write port bundle for rf_writeback_queue.
// The master side produces ALU/memory writeback requests and observes the
// retire port; the slave side is the queue itself.
interface rf_writeback_queue_if #(
  parameter int XLEN = 32
);
  // ALU path: single-cycle, never stalled
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  // Memory/load path: accepted when mem_valid && mem_ready
  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;

  // Register unit write port, one retire per cycle
  logic            RUWr;
  logic [4:0]      rd;
  logic [XLEN-1:0] RUDataWr;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    input  RUWr, rd, RUDataWr
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    output RUWr, rd, RUDataWr
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue in front of the register unit write port.
// Accepts up to two writes per cycle (ALU first, then memory), drops writes
// to x0, retires the head entry every cycle it is non-empty, and forwards the
// youngest pending value for rs1/rs2 to decode.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rf_writeback_queue_if.slave    wb,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
  output logic [XLEN-1:0]        fwd1_data,
  output logic [XLEN-1:0]        fwd2_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          entries [DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;

  logic            pop;
  logic            push_alu;
  logic            push_mem;
  logic            mem_ready_c;
  logic [CW:0]     free;
  logic [PW-1:0]   tail_p1;
  logic [PW-1:0]   mem_slot;
  logic [PW-1:0]   fwd_idx;

  // Push/pop decisions and the memory-path acceptance check.
  // NOTE: every signal driven here gets a default at the top, so no path
  // through the block leaves a value held and no latch is inferred.
  always_comb begin
    pop         = (count_q != '0);
    push_alu    = wb.alu_valid && (wb.alu_rd != 5'd0);
    // The head slot frees up this same cycle whenever something retires.
    free        = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
    mem_ready_c = !rst_n || (free >= ({{CW{1'b0}}, push_alu} + (CW+1)'(1)));
    push_mem    = wb.mem_valid && mem_ready_c && (wb.mem_rd != 5'd0);
    tail_p1     = tail_q + PW'(1);
    // ALU is older, so it takes the tail slot and memory goes right behind.
    mem_slot    = push_alu ? tail_p1 : tail_q;
  end

  assign wb.mem_ready = mem_ready_c;

  // Pointer and occupancy registers, cleared by synchronous reset.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values and ordering between always blocks cannot matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(pop);
      tail_q  <= tail_q + PW'(push_alu) + PW'(push_mem);
      count_q <= count_q + CW'(push_alu) + CW'(push_mem) - CW'(pop);
    end
  end

  // Entry storage; writes are suppressed while reset is asserted.
  // NOTE: the storage array has no reset; count_q gates every read of it, so
  // stale contents are never observable and the RAM stays reset-free.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (push_alu) entries[tail_q]   <= '{rd: wb.alu_rd, data: wb.alu_data};
      if (push_mem) entries[mem_slot] <= '{rd: wb.mem_rd, data: wb.mem_data};
    end
  end

  // Retire port: head entry whenever the queue holds something.
  always_comb begin
    wb.RUWr     = rst_n && pop;
    wb.rd       = 5'd0;
    wb.RUDataWr = '0;
    if (wb.RUWr) begin
      wb.rd       = entries[head_q].rd;
      wb.RUDataWr = entries[head_q].data;
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((rs1 != 5'd0) && (entries[fwd_idx].rd == rs1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = entries[fwd_idx].data;
        end
        if ((rs2 != 5'd0) && (entries[fwd_idx].rd == rs2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = entries[fwd_idx].data;
        end
      end
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // The retire port must never target x0, and occupancy never exceeds DEPTH.
  a_no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
    wb.RUWr |-> (wb.rd != 5'd0));
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CW'(DEPTH));

endmodule
